// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rr_arbiter
//  Description : Round-robin arbiter that funnels several upstream APB
//                requesters onto one downstream APB master port.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter #(
    parameter int NoRequesters = 4,
    parameter int AddrWidth    = 32,
    parameter int DataWidth    = 32
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NoRequesters-1:0]                     req_psel,
    input  logic [NoRequesters-1:0]                     req_penable,
    input  logic [NoRequesters-1:0]                     req_pwrite,
    input  logic [NoRequesters-1:0][AddrWidth-1:0]      req_paddr,
    input  logic [NoRequesters-1:0][2:0]                req_pprot,
    input  logic [NoRequesters-1:0][DataWidth-1:0]      req_pwdata,
    input  logic [NoRequesters-1:0][DataWidth/8-1:0]    req_pstrb,
    output logic [NoRequesters-1:0]                     req_pready,
    output logic [NoRequesters-1:0]                     req_pslverr,
    output logic [NoRequesters-1:0][DataWidth-1:0]      req_prdata,
    output logic                                        m_psel,
    output logic                                        m_penable,
    output logic                                        m_pwrite,
    output logic [AddrWidth-1:0]                        m_paddr,
    output logic [2:0]                                  m_pprot,
    output logic [DataWidth-1:0]                        m_pwdata,
    output logic [DataWidth/8-1:0]                      m_pstrb,
    input  logic                                        m_pready,
    input  logic                                        m_pslverr,
    input  logic [DataWidth-1:0]                        m_prdata,
    output logic                                        busy,
    output logic [$clog2(NoRequesters)-1:0]             grant_idx
);

    localparam int IdxWidth  = $clog2(NoRequesters);
    localparam int StrbWidth = DataWidth / 8;
    localparam logic [IdxWidth:0]   NumReq  = (IdxWidth + 1)'(NoRequesters);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NoRequesters - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic                 pwrite;
        logic [AddrWidth-1:0] paddr;
        logic [2:0]           pprot;
        logic [DataWidth-1:0] pwdata;
        logic [StrbWidth-1:0] pstrb;
    } apb_req_t;

    state_t                 state_q, state_d;
    logic [IdxWidth-1:0]    grant_q, grant_d;
    logic [IdxWidth-1:0]    rr_ptr_q, rr_ptr_d;
    logic                   dropped_q, dropped_d;
    apb_req_t               hold_q, hold_d;

    apb_req_t [NoRequesters-1:0] req_bundle;
    apb_req_t               sel_req;
    logic                   granted_live;
    logic                   winner_valid;
    logic [IdxWidth-1:0]    winner_idx;
    logic [IdxWidth:0]      cand;

    // penable is deliberately ignored: setup- and access-phase requesters compete equally
    logic unused_penable;
    assign unused_penable = ^req_penable;

    for (genvar i = 0; i < NoRequesters; i++) begin : g_bundle
        assign req_bundle[i] = '{pwrite: req_pwrite[i], paddr: req_paddr[i],
                                 pprot: req_pprot[i], pwdata: req_pwdata[i],
                                 pstrb: req_pstrb[i]};
    end

    // Scan downward so the lowest offset from rr_ptr is written last and wins
    always_comb begin
        winner_valid = 1'b0;
        winner_idx   = '0;
        cand         = '0;
        for (int k = NoRequesters - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IdxWidth + 1)'(k);
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (req_psel[cand[IdxWidth-1:0]]) begin
                winner_valid = 1'b1;
                winner_idx   = cand[IdxWidth-1:0];
            end
        end
    end

    assign granted_live = req_psel[grant_q] & ~dropped_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        dropped_d = dropped_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (winner_valid) begin
                    state_d   = SETUP;
                    grant_d   = winner_idx;
                    dropped_d = 1'b0;
                    hold_d    = req_bundle[winner_idx];
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (m_pready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Once the owner lets go of psel, freeze its last request for the rest of the transfer
        if (state_q != IDLE) begin
            if (granted_live) begin
                hold_d = req_bundle[grant_q];
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            dropped_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            dropped_q <= dropped_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        m_psel      = (state_q != IDLE);
        m_penable   = (state_q == ACCESS);
        busy        = m_psel;
        grant_idx   = grant_q;
        sel_req     = granted_live ? req_bundle[grant_q] : hold_q;
        m_pwrite    = 1'b0;
        m_paddr     = '0;
        m_pprot     = '0;
        m_pwdata    = '0;
        m_pstrb     = '0;
        req_pready  = '0;
        req_pslverr = '0;
        req_prdata  = '0;
        if (m_psel) begin
            m_pwrite = sel_req.pwrite;
            m_paddr  = sel_req.paddr;
            m_pprot  = sel_req.pprot;
            m_pwdata = sel_req.pwdata;
            m_pstrb  = sel_req.pstrb;
        end
        if ((state_q == ACCESS) && granted_live && m_pready) begin
            req_pready[grant_q]  = 1'b1;
            req_pslverr[grant_q] = m_pslverr;
            req_prdata[grant_q]  = m_prdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/apb_rr_arbiter.md
APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 SHALL have parameter NoRequesters, default 4, number of upstream APB requester ports (2..16).
REQ-002 SHALL have parameter AddrWidth, default 32, paddr width.
REQ-003 SHALL have parameter DataWidth, default 32, pwdata/prdata width; strobe width DataWidth/8.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req_psel, req_penable, req_pwrite  in  NoRequesters  per-requester APB control.
REQ-007 SHALL have ports req_paddr  in  NoRequesters x AddrWidth; req_pprot  in  NoRequesters x 3; req_pwdata  in  NoRequesters x DataWidth; req_pstrb  in  NoRequesters x DataWidth/8.
REQ-008 SHALL have ports req_pready, req_pslverr  out  NoRequesters; req_prdata  out  NoRequesters x DataWidth.
REQ-009 SHALL have ports m_psel, m_penable, m_pwrite  out  1; m_paddr, m_pprot, m_pwdata, m_pstrb  out  matching widths: downstream APB master port.
REQ-010 SHALL have ports m_pready, m_pslverr  in  1; m_prdata  in  DataWidth.
REQ-011 SHALL have ports busy  out  1 (state != IDLE) and grant_idx  out  clog2(NoRequesters) (current/last grant).

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-013 IDLE: if any req_psel high, SHALL register winner into grant_idx and go to SETUP; else stay IDLE.
REQ-014 Winner SHALL be chosen round-robin: first requester with req_psel high searching upward (with wrap) from rr_ptr; rr_ptr reset value 0.
REQ-015 SETUP: m_psel=1, m_penable=0; SHALL go to ACCESS unconditionally next cycle.
REQ-016 ACCESS: m_psel=1, m_penable=1; SHALL stay until m_pready=1, then go to IDLE and set rr_ptr = grant_idx+1 (wrap to 0 past NoRequesters-1).
REQ-017 In SETUP and ACCESS, m_pwrite/m_paddr/m_pprot/m_pwdata/m_pstrb SHALL be the granted requester's live inputs selected by registered grant_idx; in IDLE they SHALL be '0.
REQ-018 req_pready[grant_idx] SHALL equal m_pready combinationally in ACCESS only; req_prdata/req_pslverr of granted port SHALL equal m_prdata/m_pslverr when req_pready high, else '0.
REQ-019 Non-granted ports SHALL see req_pready=0, req_prdata='0, req_pslverr=0 at all times.
REQ-020 Minimum latency: requester setup cycle 0 -> m setup cycle 1 -> m access cycle 2 -> req_pready cycle 2 if m_pready=1 (one upstream wait state).
REQ-021 At least one IDLE cycle (m_psel=0) SHALL separate consecutive downstream transfers.
REQ-022 Requester in setup or access phase (req_penable either value) SHALL be equally eligible in IDLE.
REQ-023 If granted requester drops req_psel mid-transfer (protocol violation), arbiter SHALL finish the downstream transfer with the signals held at the last cycle req_psel was high and discard the response.
REQ-024 Simultaneous requests SHALL never produce more than one downstream transfer; no requester starves: any requester holding req_psel is granted within NoRequesters transfers.
REQ-025 m_pslverr SHALL be forwarded unmodified; arbiter SHALL not generate errors.

Reset
REQ-026 While rst_n=1, state SHALL be IDLE, rr_ptr=0, grant_idx=0, m_psel=0, m_penable=0, all req_pready=0, busy=0, asynchronously.
REQ-027 Reset asserted in SETUP or ACCESS SHALL abort the transfer immediately with no response delivered; first post-reset arbitration starts from rr_ptr=0.

Verification
REQ-028 Single request: req_psel[2]=1, pwrite=1, paddr=0x100, m_pready=1 -> m_psel cycles 1-2, m_penable cycle 2 only, m_paddr=0x100, req_pready[2]=1 cycle 2.
REQ-029 Contention: req_psel[0..3] all high continuously, m_pready=1 -> grant order 0,1,2,3,0; each transfer 3 cycles including IDLE.
REQ-030 Wait states: m_pready low 5 cycles in ACCESS -> m_penable high 6 cycles, m_paddr/m_pwdata stable, req_pready[grant]=1 only final cycle.
REQ-031 Error/read: read from port 1, m_prdata=0xDEADBEEF, m_pslverr=1 -> req_prdata[1]=0xDEADBEEF, req_pslverr[1]=1; other ports prdata=0.
REQ-032 Reset mid-ACCESS: rst_n=1 while busy -> m_psel=0, m_penable=0 same cycle, no req_pready; after release next grant picks lowest requesting index.
REQ-033 Random: 10000 transfers, random psel/m_pready -> assertions: one-hot granted pready, SETUP always followed by ACCESS, controls stable during ACCESS, no starvation beyond NoRequesters grants.
